// File: rtl/vadd_ctrl_pkg.sv
// vadd_ctrl_pkg: shared types, constants and size normalisation for the vadd kernel control path.
package vadd_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} seq_state_t;
  localparam int unsigned LP_DEFAULT_LENGTH_IN_BYTES = 16384;
  localparam int unsigned LP_BYTES_PER_BEAT = 64;
  // zero selects the default; otherwise round up to whole beats, clamped to the widest beat multiple
  function automatic logic [63:0] norm_size(input logic [31:0] req, input int unsigned bpb,
                                            input int unsigned width, input logic [63:0] dflt);
    logic [63:0] mask, lim, r;
    mask = ~(64'(bpb) - 64'd1);
    lim = ((64'd1 << width) - 64'd1) & mask;
    r = (64'(req) + 64'(bpb) - 64'd1) & mask;
    return req == '0 ? dflt : (r > lim ? lim : r);
  endfunction
endpackage

// File: rtl/vadd_done_collector.sv
// vadd_done_collector: sticky per-engine done bits with clear and an all-done flag.
module vadd_done_collector #(
  parameter int unsigned C_NUM_ENGINES = 2
) (
  input  logic                     ap_clk,
  input  logic                     areset,
  input  logic                     clr,
  input  logic                     en,
  input  logic [C_NUM_ENGINES-1:0] eng_done,
  output logic                     all_done
);
  logic [C_NUM_ENGINES-1:0] bits, hit;
  assign hit = eng_done & {C_NUM_ENGINES{en}};
  assign all_done = &(bits | hit);
  always_ff @(posedge ap_clk)
    bits <= (areset || clr) ? '0 : bits | hit;
endmodule

// File: rtl/vadd_kernel_sequencer.sv
// vadd_kernel_sequencer: ap_ctrl handshake, argument latching, engine launch/collect, watchdog and cycle stats.
module vadd_kernel_sequencer import vadd_ctrl_pkg::*; #(
  parameter int unsigned C_NUM_ENGINES     = 2,
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_XFER_SIZE_WIDTH = 32,
  parameter int unsigned C_BYTES_PER_BEAT  = LP_BYTES_PER_BEAT,
  parameter int unsigned C_DEFAULT_LENGTH  = LP_DEFAULT_LENGTH_IN_BYTES,
  parameter int unsigned C_TIMEOUT_CYCLES  = 0
) (
  input  logic                         ap_clk,
  input  logic                         areset,
  input  logic                         ap_start,
  output logic                         ap_idle,
  output logic                         ap_done,
  output logic                         ap_ready,
  input  logic [31:0]                  scalar00,
  input  logic [C_ADDR_WIDTH-1:0]      A,
  input  logic [C_ADDR_WIDTH-1:0]      B,
  output logic [C_NUM_ENGINES-1:0]     eng_start,
  input  logic [C_NUM_ENGINES-1:0]     eng_done,
  output logic [C_ADDR_WIDTH-1:0]      eng_addr_a,
  output logic [C_ADDR_WIDTH-1:0]      eng_addr_b,
  output logic [C_XFER_SIZE_WIDTH-1:0] eng_xfer_size,
  output logic                         stat_align_err,
  output logic                         stat_timeout,
  output logic [31:0]                  stat_cycles
);
  localparam logic [C_ADDR_WIDTH-1:0] LP_ALIGN_MASK = C_ADDR_WIDTH'(C_BYTES_PER_BEAT - 1);
  seq_state_t state;
  logic ap_start_r, start_edge, misaligned, all_done, wd_hit;
  logic [31:0] cyc, cyc_inc, wd;
  assign start_edge = ap_start && !ap_start_r && state == IDLE;
  assign misaligned = |(A & LP_ALIGN_MASK) || |(B & LP_ALIGN_MASK);
  assign cyc_inc = &cyc ? cyc : cyc + 32'd1;
  assign wd_hit = C_TIMEOUT_CYCLES != 0 && wd + 32'd1 == 32'(C_TIMEOUT_CYCLES);
  assign ap_ready = ap_done;
  vadd_done_collector #(.C_NUM_ENGINES(C_NUM_ENGINES)) u_done (
    .ap_clk(ap_clk), .areset(areset), .clr(start_edge), .en(state == BUSY),
    .eng_done(eng_done), .all_done(all_done)
  );
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state <= IDLE;
      ap_start_r <= 1'b0;
      ap_idle <= 1'b1;
      ap_done <= 1'b0;
      eng_start <= '0;
      eng_addr_a <= '0;
      eng_addr_b <= '0;
      eng_xfer_size <= C_XFER_SIZE_WIDTH'(C_DEFAULT_LENGTH);
      stat_align_err <= 1'b0;
      stat_timeout <= 1'b0;
      stat_cycles <= '0;
      cyc <= '0;
      wd <= '0;
    end else begin
      ap_start_r <= ap_start;
      ap_done <= 1'b0;
      eng_start <= '0;
      case (state)
        IDLE: if (start_edge) begin
          state <= LAUNCH;
          ap_idle <= 1'b0;
          eng_start <= misaligned ? '0 : '1;
          eng_addr_a <= A;
          eng_addr_b <= B;
          eng_xfer_size <= C_XFER_SIZE_WIDTH'(norm_size(scalar00, C_BYTES_PER_BEAT, C_XFER_SIZE_WIDTH, 64'(C_DEFAULT_LENGTH)));
          stat_align_err <= misaligned;
          stat_timeout <= 1'b0;
          stat_cycles <= '0;
          cyc <= '0;
          wd <= '0;
        end
        LAUNCH: begin
          cyc <= cyc_inc;
          state <= stat_align_err ? DONE : BUSY;
          ap_done <= stat_align_err;
          stat_cycles <= stat_align_err ? cyc_inc : stat_cycles;
        end
        BUSY: begin
          cyc <= cyc_inc;
          wd <= wd + 32'd1;
          if (all_done || wd_hit) begin
            state <= DONE;
            ap_done <= 1'b1;
            stat_cycles <= cyc_inc;
            stat_timeout <= !all_done;
          end
        end
        default: begin
          state <= IDLE;
          ap_idle <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/vadd_kernel_sequencer.md
# vadd_kernel_sequencer

Kernel-level control sequencer for the two-engine vector-add datapath (operand-A reader and operand-B adder/writer). It implements the host `ap_start`/`ap_idle`/`ap_done`/`ap_ready` handshake and latches the run arguments. It validates and normalises the transfer size, launches all engines with a single start pulse, and collects their done pulses. It also provides a timeout watchdog and a run cycle counter. It sits between the kernel control-register block and the engine instances inside the kernel top wrapper.

## Interface
Parameters:
- `C_NUM_ENGINES`, default 2: number of engines sequenced.
- `C_ADDR_WIDTH`, default 64: buffer address width.
- `C_XFER_SIZE_WIDTH`, default 32: transfer size width, in bytes.
- `C_BYTES_PER_BEAT`, default 64: AXI beat size; must be a power of 2.
- `C_DEFAULT_LENGTH`, default 16384: size used when `scalar00` is 0.
- `C_TIMEOUT_CYCLES`, default 0: watchdog limit; 0 disables the watchdog.

Ports:
- `ap_clk`  in  1  clock.
- `areset`  in  1  reset, synchronous, active-high.
- `ap_start`  in  1  host start, level; only its rising edge is acted on.
- `ap_idle`  out  1  kernel idle.
- `ap_done`  out  1  run complete, 1-cycle pulse.
- `ap_ready`  out  1  equals `ap_done`.
- `scalar00`  in  32  requested length in bytes.
- `A`, `B`  in  C_ADDR_WIDTH  buffer base addresses.
- `eng_start`  out  C_NUM_ENGINES  per-engine start pulse.
- `eng_done`  in  C_NUM_ENGINES  per-engine done pulse.
- `eng_addr_a`, `eng_addr_b`  out  C_ADDR_WIDTH  latched base addresses.
- `eng_xfer_size`  out  C_XFER_SIZE_WIDTH  normalised size in bytes.
- `stat_align_err`  out  1  last run was rejected for misalignment.
- `stat_timeout`  out  1  last run ended by the watchdog.
- `stat_cycles`  out  32  cycle count of the last run.

## Operation
State machine:
- **IDLE → LAUNCH** on a start edge (`ap_start & ~ap_start_r`).
- **LAUNCH → BUSY** unconditionally, or **LAUNCH → DONE** on alignment error.
- **BUSY → DONE** when all done bits are set, or when the watchdog expires.
- **DONE → IDLE** unconditionally.

Start-edge rules:
- Start edges seen outside IDLE are ignored.
- `ap_start` held high across runs does not restart the kernel; it must fall and rise again.

On the start edge:
- Latch `A`, `B` and the size.
- Size rule: if `scalar00` is 0, use `C_DEFAULT_LENGTH`. Otherwise round up to a multiple of `C_BYTES_PER_BEAT`, saturating at the largest multiple that fits in `C_XFER_SIZE_WIDTH`.
- Clear `stat_*` and the done bits.

Alignment check:
- If the low log2(`C_BYTES_PER_BEAT`) bits of `A` or `B` are non-zero, set `stat_align_err`.
- On alignment error, `eng_start` is never pulsed and the FSM goes directly to DONE.

Done collection:
- Per-engine sticky bit, set by `eng_done[i]` in BUSY only.
- `eng_done` outside BUSY is ignored.
- Simultaneous done pulses from several engines are all captured.

Watchdog:
- Active only when `C_TIMEOUT_CYCLES` > 0.
- Counts cycles spent in BUSY; on reaching `C_TIMEOUT_CYCLES`, set `stat_timeout` and go to DONE.

Cycle counter:
- Counts cycles from LAUNCH through the cycle before DONE.
- Saturates at 2^32−1.
- Copied to `stat_cycles` in DONE.

Reset:
- Forces IDLE and clears the done bits, `stat_*` and `ap_start_r`, from any state.
- An engine run that was in flight is abandoned; done pulses arriving after reset are ignored.

## Timing
Reset values:
- `ap_idle`: 1.
- `ap_done`, `ap_ready`, `eng_start`: 0.
- `eng_addr_*`: 0.
- `eng_xfer_size`: `C_DEFAULT_LENGTH`.
- `stat_*`: 0.

Cycle sequence:
- **Cycle t:** start edge sampled.
- **Cycle t+1:** LAUNCH; `ap_idle`=0; `eng_start`=all ones for exactly this cycle; `eng_addr_*` and `eng_xfer_size` are valid from this cycle and held until the next launch.
- **Cycle t+2:** BUSY.
- **Cycle k:** the last outstanding `eng_done` arrives.
- **Cycle k+1:** DONE; `ap_done`=`ap_ready`=1 for this cycle only.
- **Cycle k+2:** IDLE; `ap_idle`=1.

Special cases:
- Alignment error: `ap_done` at t+2, `ap_idle` at t+3.
- Timeout: DONE occurs in the cycle after the count reaches the limit.
- `stat_cycles` = k − t for a normal run.

## Structure
Package `vadd_ctrl_pkg` holds:
- the state enum `seq_state_t` (IDLE, LAUNCH, BUSY, DONE);
- `LP_DEFAULT_LENGTH_IN_BYTES` = 16384;
- `LP_BYTES_PER_BEAT` = 64;
- the size-normalisation function.

One sub-module: `vadd_done_collector`, which holds the sticky per-engine done bits with clear and all-done output.

## Test plan
- **Nominal run:** `A`=0x1000, `B`=0x2000, `scalar00`=256; engines pulse done at +10 and +14 cycles. Required: one `eng_start` pulse; `eng_xfer_size`=256; `ap_done` one cycle after the second done; `stat_cycles`=15.
- **Default and rounding:** `scalar00`=0 → size 16384. `scalar00`=100 → 128. `scalar00`=0xFFFFFFFF → 0xFFFFFFC0.
- **Misaligned address:** `A`=0x1004. Required: no `eng_start`; `stat_align_err`=1; `ap_done` two cycles after the start edge.
- **Done-edge cases:** simultaneous `eng_done`=2'b11 → DONE next cycle. A stray `eng_done` in IDLE is ignored and does not shorten the next run.
- **Watchdog:** `C_TIMEOUT_CYCLES`=50, engine 1 never completes. Required: `stat_timeout`=1; `ap_done` pulses after 50 BUSY cycles.
- **Reset and start re-arm:** `areset` asserted in BUSY → `ap_idle`=1 on the next cycle and no `ap_done`. `ap_start` held high after a run → no second launch until it falls and rises again.
